// File: rtl/spi_reg_controller.sv
// rtl/spi_reg_controller.sv - SPI secondary word stream to register-bank access sequencer
// Byte 0 of a CS frame is a command (R/W + start address); later bytes stream data with auto-increment.
module spi_reg_controller #(
    parameter int                  WordBits  = 8,
    parameter int                  AddrBits  = 7,
    parameter int                  NumRegs   = 128,
    parameter logic [WordBits-2:0] StatusTag = 7'h52
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs,
    input  logic                word_ready,
    input  logic [WordBits-1:0] data_word_received,
    output logic [WordBits-1:0] data_word_to_send,
    output logic [AddrBits-1:0] reg_addr,
    output logic                reg_wr_en,
    output logic [WordBits-1:0] reg_wr_data,
    output logic                reg_rd_en,
    input  logic [WordBits-1:0] reg_rd_data,
    output logic                txn_done,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ,
        DISCARD
    } state_t;

    localparam logic [AddrBits:0]   ADDR_LIMIT = (AddrBits+1)'(NumRegs);
    localparam logic [AddrBits-1:0] ADDR_LAST  = AddrBits'(NumRegs - 1);

    state_t              state;
    logic                cs_q;
    logic                rd_q;
    logic                data_seen;
    logic                err_at_start;
    logic                bad_in_frame;

    logic                cs_rise;
    logic                cs_fall;
    logic                word_ok;
    logic                cmd_write;
    logic [AddrBits-1:0] cmd_addr;
    logic                cmd_bad;
    logic [AddrBits-1:0] next_addr;
    logic [WordBits-1:0] status_word;

    assign cs_rise     = cs & ~cs_q;
    assign cs_fall     = ~cs & cs_q;
    // A word completing in the same cycle as the cs fall belongs to no frame.
    assign word_ok     = word_ready & ~cs & ~cs_q;
    assign cmd_write   = data_word_received[WordBits-1];
    assign cmd_addr    = data_word_received[AddrBits-1:0];
    assign cmd_bad     = {1'b0, cmd_addr} >= ADDR_LIMIT;
    assign next_addr   = (reg_addr == ADDR_LAST) ? '0 : reg_addr + AddrBits'(1);
    assign status_word = {StatusTag, err};

    always_ff @(posedge clk) begin
        cs_q <= cs;
        if (!rst_n) begin
            state             <= IDLE;
            data_word_to_send <= {StatusTag, 1'b0};
            reg_addr          <= '0;
            reg_wr_en         <= 1'b0;
            reg_wr_data       <= '0;
            reg_rd_en         <= 1'b0;
            txn_done          <= 1'b0;
            err               <= 1'b0;
            rd_q              <= 1'b0;
            data_seen         <= 1'b0;
            err_at_start      <= 1'b0;
            bad_in_frame      <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            txn_done  <= 1'b0;
            rd_q      <= reg_rd_en;
            if (reg_wr_en) begin
                reg_addr <= next_addr;
            end
            if (cs_rise) begin
                state             <= IDLE;
                data_word_to_send <= status_word;
                txn_done          <= data_seen;
                // The error was reported in this frame's status; keep it if the frame re-raised it.
                if (err_at_start && !bad_in_frame) begin
                    err <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        data_word_to_send <= status_word;
                        if (cs_fall) begin
                            state        <= CMD;
                            data_seen    <= 1'b0;
                            bad_in_frame <= 1'b0;
                            err_at_start <= err;
                        end
                    end
                    CMD: begin
                        data_word_to_send <= status_word;
                        if (word_ok) begin
                            if (cmd_bad) begin
                                err          <= 1'b1;
                                bad_in_frame <= 1'b1;
                                state        <= DISCARD;
                            end else if (cmd_write) begin
                                reg_addr <= cmd_addr;
                                state    <= WRITE;
                            end else begin
                                reg_addr  <= cmd_addr;
                                reg_rd_en <= 1'b1;
                                state     <= READ;
                            end
                        end
                    end
                    WRITE: begin
                        data_word_to_send <= status_word;
                        if (word_ok) begin
                            reg_wr_en   <= 1'b1;
                            reg_wr_data <= data_word_received;
                            data_seen   <= 1'b1;
                        end
                    end
                    READ: begin
                        if (rd_q) begin
                            data_word_to_send <= reg_rd_data;
                        end
                        // Prefetch the next register so it is ready before the following latch.
                        if (word_ok) begin
                            reg_addr  <= next_addr;
                            reg_rd_en <= 1'b1;
                            data_seen <= 1'b1;
                        end
                    end
                    DISCARD: begin
                        data_word_to_send <= status_word;
                        if (word_ok) begin
                            data_seen <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_controller.sv
// tb/tb_spi_reg_controller.sv - self-checking bench for spi_reg_controller
module tb_spi_reg_controller;

    localparam int         WB  = 8;
    localparam int         AB  = 7;
    localparam int         NR  = 100;
    localparam logic [6:0] TAG = 7'h52;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b1;
    logic          word_ready = 1'b0;
    logic [WB-1:0] rx = '0;
    logic [WB-1:0] data_word_to_send;
    logic [AB-1:0] reg_addr;
    logic          reg_wr_en;
    logic [WB-1:0] reg_wr_data;
    logic          reg_rd_en;
    logic [WB-1:0] reg_rd_data = '0;
    logic          txn_done;
    logic          err;

    always #5 clk = ~clk;

    spi_reg_controller #(
        .WordBits (WB),
        .AddrBits (AB),
        .NumRegs  (NR),
        .StatusTag(TAG)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cs                (cs),
        .word_ready        (word_ready),
        .data_word_received(rx),
        .data_word_to_send (data_word_to_send),
        .reg_addr          (reg_addr),
        .reg_wr_en         (reg_wr_en),
        .reg_wr_data       (reg_wr_data),
        .reg_rd_en         (reg_rd_en),
        .reg_rd_data       (reg_rd_data),
        .txn_done          (txn_done),
        .err               (err)
    );

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] mem[128];
    logic [7:0] ref_mem[128];
    logic [7:0] fdata[8];
    int         wr_a_q[$];
    int         wr_d_q[$];
    int         rd_a_q[$];
    int         txn_cnt = 0;
    bit         both_seen = 0;
    bit         err_model = 0;

    // Register bank and strobe logger, sampled on the inactive edge.
    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_a_q.push_back(int'(reg_addr));
            wr_d_q.push_back(int'(reg_wr_data));
            mem[reg_addr] = reg_wr_data;
        end
        if (reg_rd_en) begin
            rd_a_q.push_back(int'(reg_addr));
            reg_rd_data = mem[reg_addr];
        end
        if (reg_wr_en && reg_rd_en) both_seen = 1;
        if (txn_done) txn_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_a_q.delete();
        wr_d_q.delete();
        rd_a_q.delete();
        txn_cnt   = 0;
        both_seen = 0;
    endtask

    task automatic send_word(input logic [7:0] w, output logic [7:0] seen);
        word_ready = 1'b1;
        rx         = w;
        seen       = data_word_to_send;
        tick(1);
        word_ready = 1'b0;
        rx         = 8'($urandom);
        tick(6);
    endtask

    // One complete frame: command byte then n data bytes from fdata, checked against the model.
    task automatic frame(input bit is_wr, input int addr, input int n);
        logic [7:0] lat[9];
        logic [7:0] st;
        logic [7:0] exp;
        bit         bad;
        bad = (addr >= NR);
        st  = {TAG, err_model};
        clear_logs();
        cs = 1'b0;
        tick(2);
        send_word({is_wr, 7'(addr)}, lat[0]);
        for (int k = 1; k <= n; k++) send_word(fdata[k-1], lat[k]);
        tick(2);
        cs = 1'b1;
        tick(4);
        for (int k = 0; k <= n; k++) begin
            if (k == 0) exp = st;
            else if (bad) exp = {TAG, 1'b1};
            else if (is_wr) exp = st;
            else exp = ref_mem[(addr + k - 1) % NR];
            chk($sformatf("latch%0d a=%0d", k, addr), lat[k], exp);
        end
        if (!bad && is_wr) begin
            chk("wr_count", wr_a_q.size(), n);
            for (int k = 0; k < n && k < wr_a_q.size(); k++) begin
                chk($sformatf("wr_addr%0d", k), wr_a_q[k], (addr + k) % NR);
                chk($sformatf("wr_data%0d", k), wr_d_q[k], fdata[k]);
            end
            for (int k = 0; k < n; k++) ref_mem[(addr + k) % NR] = fdata[k];
        end else begin
            chk("wr_none", wr_a_q.size(), 0);
        end
        if (!bad && !is_wr) begin
            chk("rd_count", rd_a_q.size(), n + 1);
            for (int k = 0; k <= n && k < rd_a_q.size(); k++)
                chk($sformatf("rd_addr%0d", k), rd_a_q[k], (addr + k) % NR);
        end else begin
            chk("rd_none", rd_a_q.size(), 0);
        end
        if (bad) err_model = 1;
        else if (st[0]) err_model = 0;
        chk("err", err, err_model);
        chk("txn_done", txn_cnt, (n >= 1) ? 1 : 0);
        chk("status_after", data_word_to_send, {TAG, err_model});
        chk("strobe_excl", both_seen, 0);
    endtask

    initial begin
        logic [7:0] dummy;
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[3] = 8'hAB; ref_mem[3] = 8'hAB;
        mem[4] = 8'hCD; ref_mem[4] = 8'hCD;

        tick(3);
        chk("rst_send", data_word_to_send, 8'hA4);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wr_en", reg_wr_en, 0);
        chk("rst_wr_data", reg_wr_data, 0);
        chk("rst_rd_en", reg_rd_en, 0);
        chk("rst_txn", txn_done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick(3);

        fdata[0] = 8'h11; fdata[1] = 8'h22;
        frame(1, 5, 2);
        frame(0, 3, 3);
        fdata[0] = 8'h31; fdata[1] = 8'h32; fdata[2] = 8'h33;
        frame(1, NR - 1, 3);
        frame(1, NR, 2);
        fdata[0] = 8'h5A;
        frame(0, 10, 1);

        // Abort: cs rises two cycles after a write word completes.
        clear_logs();
        cs = 1'b0;
        tick(2);
        send_word(8'h85, dummy);
        word_ready = 1'b1; rx = 8'h77;
        tick(1);
        word_ready = 1'b0;
        tick(1);
        cs = 1'b1;
        tick(3);
        for (int i = 0; i < 2; i++) send_word(8'h99, dummy);
        chk("abort_wr_count", wr_a_q.size(), 1);
        if (wr_a_q.size() == 1) begin
            chk("abort_wr_addr", wr_a_q[0], 5);
            chk("abort_wr_data", wr_d_q[0], 8'h77);
        end
        chk("abort_txn", txn_cnt, 1);
        chk("abort_status", data_word_to_send, 8'hA4);
        ref_mem[5] = 8'h77;

        for (int i = 0; i < 30; i++) begin
            for (int j = 0; j < 8; j++) fdata[j] = 8'($urandom);
            frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), int'($urandom_range(0, 4)));
        end

        // Reset in the middle of a read frame that began with err set.
        frame(0, 120, 0);
        cs = 1'b0;
        tick(2);
        send_word(8'h03, dummy);
        word_ready = 1'b1; rx = 8'h00;
        tick(1);
        word_ready = 1'b0;
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_send", data_word_to_send, 8'hA4);
        chk("mid_rst_addr", reg_addr, 0);
        chk("mid_rst_wr_en", reg_wr_en, 0);
        chk("mid_rst_rd_en", reg_rd_en, 0);
        chk("mid_rst_txn", txn_done, 0);
        chk("mid_rst_err", err, 0);
        clear_logs();
        rst_n = 1'b1;
        err_model = 0;
        tick(3);
        for (int i = 0; i < 2; i++) send_word(8'h04, dummy);
        cs = 1'b1;
        tick(4);
        chk("post_rst_rd", rd_a_q.size(), 0);
        chk("post_rst_wr", wr_a_q.size(), 0);
        chk("post_rst_txn", txn_cnt, 0);
        chk("post_rst_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
